combo_vault_controller: RTL and testbench

COMBO_VAULT_CONTROLLER -- requirements
Module: combo_vault_controller

---
 rtl/vault_pkg.sv | 38 +++
 rtl/vault_lockout_timer.sv | 48 ++++
 rtl/combo_vault_controller.sv | 196 +++++++++++++++++++
 tb/tb_combo_vault_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vault_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vault_pkg
//  Description : Shared types and constants for the combination vault
//                controller. Holds the controller state encoding, the
//                one-hot LED bit positions and the default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package vault_pkg;

    // Controller states. Explicit 3-bit width; codes 6 and 7 are unused.
    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_STARTED  = 3'd1,
        ST_SEEK     = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_RELOCK   = 3'd4,
        ST_LOCKOUT  = 3'd5
    } vault_state_t;

    // Bit positions within the one-hot state_led output.
    localparam int c_LED_LOCKED   = 0;
    localparam int c_LED_STARTED  = 1;
    localparam int c_LED_SEEK     = 2;
    localparam int c_LED_UNLOCKED = 3;
    localparam int c_LED_LOCKOUT  = 4;
    localparam int c_LED_RELOCK   = 5;
    localparam int c_LED_W        = 6;

    // Default parameter values.
    localparam int          c_CODE_W_DEF         = 5;
    localparam int          c_NUM_COMB_DEF       = 3;
    localparam logic [14:0] c_COMB_INIT_DEF      = {5'd20, 5'd3, 5'd7};
    localparam int          c_MAX_FAILS_DEF      = 3;
    localparam int          c_LOCKOUT_CYCLES_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/vault_lockout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vault_lockout_timer
//  Description : Down-counter that times the lockout period. A load pulse
//                arms it for LOCKOUT_CYCLES cycles of enable; done is high
//                during the final enabled cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock  in   rising-edge clock
//    reset  in   synchronous active-high reset (counter cleared)
//    load   in   arm the timer (takes effect on the next edge)
//    en     in   count down while high
//    done   out  high in the last cycle of the armed period
// ============================================================================
module vault_lockout_timer
    import vault_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = c_LOCKOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int c_CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    // Loaded with N-1 so that the cycle that sees zero is the Nth cycle.
    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_LOAD_VAL;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign done = en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/combo_vault_controller.sv
`default_nettype none
// ============================================================================
//  Module      : combo_vault_controller
//  Description : Combination-dial vault controller. The user zeroes the dial
//                moving down, then dials each combination step alternating
//                up/down. Repeated failures trigger a timed lockout. While
//                unlocked the combination may be rewritten.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock        in   rising-edge clock
//    reset        in   synchronous active-high reset
//    direction    in   1 = dial moving up, 0 = dial moving down
//    vault_code   in   current dial value
//    comb_wr_en   in   combination write strobe (honoured only when unlocked)
//    comb_wr_idx  in   combination step to write
//    comb_wr_data in   new value for that step
//    unlocked     out  vault is open
//    locked_out   out  lockout period in progress
//    step         out  combination step currently being sought
//    fail_cnt     out  consecutive failed attempts (saturating)
//    state_led    out  one-hot {RELOCK,LOCKOUT,UNLOCKED,SEEK,STARTED,LOCKED}
// ============================================================================
module combo_vault_controller
    import vault_pkg::*;
#(
    parameter int                         CODE_W         = c_CODE_W_DEF,
    parameter int                         NUM_COMB       = c_NUM_COMB_DEF,
    parameter logic [NUM_COMB*CODE_W-1:0] COMB_INIT      = c_COMB_INIT_DEF,
    parameter int                         MAX_FAILS      = c_MAX_FAILS_DEF,
    parameter int                         LOCKOUT_CYCLES = c_LOCKOUT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              direction,
    input  logic [CODE_W-1:0] vault_code,
    input  logic              comb_wr_en,
    input  logic [2:0]        comb_wr_idx,
    input  logic [CODE_W-1:0] comb_wr_data,
    output logic              unlocked,
    output logic              locked_out,
    output logic [2:0]        step,
    output logic [3:0]        fail_cnt,
    output logic [5:0]        state_led
);

    localparam logic [3:0] c_MAX_FAILS = 4'(MAX_FAILS);
    localparam logic [2:0] c_LAST_STEP = 3'(NUM_COMB - 1);
    localparam logic [3:0] c_NUM_COMB  = 4'(NUM_COMB);

    vault_state_t               r_state;
    logic [2:0]                 r_k;
    logic [3:0]                 r_fail;
    logic [NUM_COMB*CODE_W-1:0] r_comb;

    logic [CODE_W-1:0] w_target;
    logic [CODE_W-1:0] w_prev;
    logic              w_req;
    logic              w_grace;
    logic              w_dir_ok;
    logic              w_before;
    logic              w_hit;
    logic              w_seek_fail;
    logic [3:0]        w_fail_next;
    logic              w_lock_load;
    logic              w_lock_done;
    logic              w_wr_ok;

    // Select comb[k] and comb[k-1] with a compare-per-step mux so the 3-bit
    // step index never addresses past the configured number of steps.
    always_comb begin
        w_target = '0;
        w_prev   = '0;
        for (int i = 0; i < NUM_COMB; i++) begin
            if (r_k == 3'(i)) begin
                w_target = r_comb[i*CODE_W +: CODE_W];
            end
            if (r_k == 3'(i + 1)) begin
                w_prev = r_comb[i*CODE_W +: CODE_W];
            end
        end
    end

    // Even steps are dialled upward, odd steps downward.
    assign w_req    = ~r_k[0];
    // Sitting on the previous step's value is a legal pause while reversing.
    assign w_grace  = (r_k != 3'd0) && (vault_code == w_prev);
    assign w_dir_ok = (direction == w_req);
    assign w_before = w_req ? (vault_code < w_target) : (vault_code > w_target);
    assign w_hit    = !w_grace && w_dir_ok && (vault_code == w_target);
    assign w_seek_fail = !w_grace && !(w_dir_ok && ((vault_code == w_target) || w_before));

    assign w_fail_next = (r_fail >= c_MAX_FAILS) ? c_MAX_FAILS : (r_fail + 4'd1);
    assign w_lock_load = (r_state == ST_SEEK) && w_seek_fail && (w_fail_next == c_MAX_FAILS);

    assign w_wr_ok = comb_wr_en && (r_state == ST_UNLOCKED) && ({1'b0, comb_wr_idx} < c_NUM_COMB);

    vault_lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clock (clock),
        .reset (reset),
        .load  (w_lock_load),
        .en    (r_state == ST_LOCKOUT),
        .done  (w_lock_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_LOCKED;
            r_k     <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (!direction && (vault_code == '0)) begin
                        r_state <= ST_STARTED;
                    end
                end
                ST_STARTED: begin
                    if (direction && (vault_code != '0)) begin
                        r_state <= ST_SEEK;
                        r_k     <= 3'd0;
                    end
                end
                ST_SEEK: begin
                    if (w_hit) begin
                        if (r_k == c_LAST_STEP) begin
                            r_state <= ST_UNLOCKED;
                            r_k     <= 3'd0;
                            r_fail  <= 4'd0;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end else if (w_seek_fail) begin
                        r_fail  <= w_fail_next;
                        r_k     <= 3'd0;
                        r_state <= w_lock_load ? ST_LOCKOUT : ST_LOCKED;
                    end
                end
                ST_UNLOCKED: begin
                    if (!direction) begin
                        r_state <= ST_RELOCK;
                    end
                end
                ST_RELOCK: begin
                    if (!direction && (vault_code == '0)) begin
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_lock_done) begin
                        r_state <= ST_LOCKED;
                        r_fail  <= 4'd0;
                    end
                end
                default: begin
                    r_state <= ST_LOCKED;
                    r_k     <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_comb <= COMB_INIT;
        end else begin
            for (int i = 0; i < NUM_COMB; i++) begin
                if (w_wr_ok && (comb_wr_idx == 3'(i))) begin
                    r_comb[i*CODE_W +: CODE_W] <= comb_wr_data;
                end
            end
        end
    end

    assign unlocked   = (r_state == ST_UNLOCKED);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign step       = r_k;
    assign fail_cnt   = r_fail;

    always_comb begin
        state_led = '0;
        case (r_state)
            ST_LOCKED:   state_led[c_LED_LOCKED]   = 1'b1;
            ST_STARTED:  state_led[c_LED_STARTED]  = 1'b1;
            ST_SEEK:     state_led[c_LED_SEEK]     = 1'b1;
            ST_UNLOCKED: state_led[c_LED_UNLOCKED] = 1'b1;
            ST_RELOCK:   state_led[c_LED_RELOCK]   = 1'b1;
            ST_LOCKOUT:  state_led[c_LED_LOCKOUT]  = 1'b1;
            default:     state_led = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_combo_vault_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_vault_controller
//  Description : Self-checking bench for combo_vault_controller: a table of
//                directed vectors, hand-written multi-cycle sequences and a
//                randomized run compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_vault_controller;

    localparam int CODE_W         = 5;
    localparam int NUM_COMB       = 3;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;

    localparam logic [5:0] L_LOCKED   = 6'b000001;
    localparam logic [5:0] L_STARTED  = 6'b000010;
    localparam logic [5:0] L_SEEK     = 6'b000100;
    localparam logic [5:0] L_OPEN     = 6'b001000;
    localparam logic [5:0] L_LOCKOUT  = 6'b010000;
    localparam logic [5:0] L_RELOCK   = 6'b100000;

    logic        clock = 1'b0;
    logic        reset;
    logic        direction;
    logic [4:0]  vault_code;
    logic        comb_wr_en;
    logic [2:0]  comb_wr_idx;
    logic [4:0]  comb_wr_data;
    logic        unlocked;
    logic        locked_out;
    logic [2:0]  step;
    logic [3:0]  fail_cnt;
    logic [5:0]  state_led;

    always #5 clock = ~clock;

    combo_vault_controller #(
        .CODE_W         (CODE_W),
        .NUM_COMB       (NUM_COMB),
        .COMB_INIT      ({5'd20, 5'd3, 5'd7}),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .direction    (direction),
        .vault_code   (vault_code),
        .comb_wr_en   (comb_wr_en),
        .comb_wr_idx  (comb_wr_idx),
        .comb_wr_data (comb_wr_data),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .step         (step),
        .fail_cnt     (fail_cnt),
        .state_led    (state_led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_ARMED, M_DIALING, M_OPEN, M_CLOSING, M_JAIL} mphase_t;
    mphase_t m_ph;
    int      m_k;
    int      m_fails;
    int      m_jail_left;
    int      m_comb[NUM_COMB];

    task automatic model_step(input bit rst, input bit d, input int c,
                              input bit we, input int wi, input int wd);
        bit up;
        int tgt;
        bit wr;
        if (rst) begin
            m_ph = M_IDLE; m_k = 0; m_fails = 0; m_jail_left = 0;
            m_comb = '{7, 3, 20};
            return;
        end
        wr = we && (m_ph == M_OPEN) && (wi < NUM_COMB);
        case (m_ph)
            M_IDLE:    if (!d && c == 0) m_ph = M_ARMED;
            M_ARMED:   if (d && c != 0) begin m_ph = M_DIALING; m_k = 0; end
            M_DIALING: begin
                up  = (m_k % 2 == 0);
                tgt = m_comb[m_k];
                if (m_k > 0 && c == m_comb[m_k-1]) begin
                    // pause on previous value while reversing
                end else if (d == up && c == tgt) begin
                    if (m_k == NUM_COMB - 1) begin m_ph = M_OPEN; m_k = 0; m_fails = 0; end
                    else m_k = m_k + 1;
                end else if (d == up && (up ? (c < tgt) : (c > tgt))) begin
                    // still approaching the target
                end else begin
                    m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
                    m_k = 0;
                    if (m_fails == MAX_FAILS) begin m_ph = M_JAIL; m_jail_left = LOCKOUT_CYCLES; end
                    else m_ph = M_IDLE;
                end
            end
            M_OPEN:    if (!d) m_ph = M_CLOSING;
            M_CLOSING: if (!d && c == 0) m_ph = M_IDLE;
            M_JAIL: begin
                m_jail_left = m_jail_left - 1;
                if (m_jail_left == 0) begin m_ph = M_IDLE; m_fails = 0; end
            end
            default: m_ph = M_IDLE;
        endcase
        if (wr) m_comb[wi] = wd;
    endtask

    function automatic logic [14:0] m_expect();
        logic [5:0] led;
        case (m_ph)
            M_IDLE:    led = L_LOCKED;
            M_ARMED:   led = L_STARTED;
            M_DIALING: led = L_SEEK;
            M_OPEN:    led = L_OPEN;
            M_CLOSING: led = L_RELOCK;
            default:   led = L_LOCKOUT;
        endcase
        return {(m_ph == M_OPEN), (m_ph == M_JAIL), 3'(m_k), 4'(m_fails), led};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_bundle();
        return {unlocked, locked_out, step, fail_cnt, state_led};
    endfunction

    // Drive one cycle, advance the model on the same edge, sample 1 unit later.
    task automatic cycle(input bit rst, input bit d, input int c, input bit we,
                         input int wi, input int wd, input bit chk, input string tag);
        int c5;
        c5 = c & 31;
        reset        = rst;
        direction    = d;
        vault_code   = 5'(c5);
        comb_wr_en   = we;
        comb_wr_idx  = 3'(wi);
        comb_wr_data = 5'(wd);
        @(posedge clock);
        model_step(rst, d, c5, we, wi & 7, wd & 31);
        #1;
        if (chk) check(tag, 32'(dut_bundle()), 32'(m_expect()));
    endtask

    task automatic dial(input bit d, input int c);
        cycle(1'b0, d, c, 1'b0, 0, 0, 1'b1, "model");
    endtask

    task automatic dial_wr(input bit d, input int c, input int wi, input int wd);
        cycle(1'b0, d, c, 1'b1, wi, wd, 1'b1, "model_wr");
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         d;
        int         c;
        bit         we;
        int         wi;
        int         wd;
        bit         exp_u;
        bit         exp_lo;
        int         exp_step;
        int         exp_fail;
        logic [5:0] exp_led;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cnt;
        int sel;
        int cval;
        logic [14:0] exp;

        reset = 1'b1; direction = 1'b0; vault_code = '0;
        comb_wr_en = 1'b0; comb_wr_idx = '0; comb_wr_data = '0;

        // Reset state; inputs (0,0) would otherwise start an attempt.
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, "");
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, "");
        check("reset_state", 32'(dut_bundle()), 32'({1'b0, 1'b0, 3'd0, 4'd0, L_LOCKED}));

        //                rst d  c  we wi wd  u lo st f  led
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_STARTED});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, L_SEEK});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 0, 1, 0, L_SEEK});
        tbl.push_back('{0, 0, 5, 0, 0, 0, 0, 0, 1, 0, L_SEEK});
        tbl.push_back('{0, 0, 3, 0, 0, 0, 0, 0, 2, 0, L_SEEK});
        tbl.push_back('{0, 1, 10, 0, 0, 0, 0, 0, 2, 0, L_SEEK});
        tbl.push_back('{0, 1, 20, 0, 0, 0, 1, 0, 0, 0, L_OPEN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_RELOCK});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_LOCKED});
        // up-move past the step0 value on a down step: fails
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_STARTED});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, L_SEEK});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 0, 1, 0, L_SEEK});
        tbl.push_back('{0, 1, 8, 0, 0, 0, 0, 0, 0, 1, L_LOCKED});
        // reversal grace in both directions, then overshoot on the last step
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, L_STARTED});
        tbl.push_back('{0, 1, 2, 0, 0, 0, 0, 0, 0, 1, L_SEEK});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 0, 1, 1, L_SEEK});
        tbl.push_back('{0, 0, 7, 0, 0, 0, 0, 0, 1, 1, L_SEEK});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 0, 1, 1, L_SEEK});
        tbl.push_back('{0, 0, 3, 0, 0, 0, 0, 0, 2, 1, L_SEEK});
        tbl.push_back('{0, 0, 3, 0, 0, 0, 0, 0, 2, 1, L_SEEK});
        tbl.push_back('{0, 1, 21, 0, 0, 0, 0, 0, 0, 2, L_LOCKED});
        // success clears the failure count
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, L_STARTED});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 2, L_SEEK});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 0, 1, 2, L_SEEK});
        tbl.push_back('{0, 0, 3, 0, 0, 0, 0, 0, 2, 2, L_SEEK});
        tbl.push_back('{0, 1, 20, 0, 0, 0, 1, 0, 0, 0, L_OPEN});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_RELOCK});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_LOCKED});
        // hold conditions in LOCKED / STARTED, approach then wrong direction
        tbl.push_back('{0, 1, 0, 1, 1, 2, 0, 0, 0, 0, L_LOCKED});
        tbl.push_back('{0, 0, 5, 0, 0, 0, 0, 0, 0, 0, L_LOCKED});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_STARTED});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, L_STARTED});
        tbl.push_back('{0, 0, 4, 0, 0, 0, 0, 0, 0, 0, L_STARTED});
        tbl.push_back('{0, 1, 4, 0, 0, 0, 0, 0, 0, 0, L_SEEK});
        tbl.push_back('{0, 1, 6, 0, 0, 0, 0, 0, 0, 0, L_SEEK});
        tbl.push_back('{0, 0, 6, 0, 0, 0, 0, 0, 0, 1, L_LOCKED});
        // reset beats the LOCKED->STARTED transition
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, L_LOCKED});

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].d, tbl[i].c, tbl[i].we, tbl[i].wi, tbl[i].wd, 1'b0, "");
            exp = {tbl[i].exp_u, tbl[i].exp_lo, 3'(tbl[i].exp_step), 4'(tbl[i].exp_fail), tbl[i].exp_led};
            check($sformatf("vec%0d", i), 32'(dut_bundle()), 32'(exp));
        end

        // ---- three overshoot failures -> lockout of exactly 16 cycles ----
        for (int a = 0; a < 3; a++) begin
            dial(0, 0); dial(1, 1); dial(1, 9);
        end
        check("lockout_entry", 32'({locked_out, fail_cnt}), 32'({1'b1, 4'd3}));
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'($urandom % 2), int'($urandom % 32), 1'($urandom % 2),
                  int'($urandom % 8), int'($urandom % 32), 1'b1, "lockout_model");
            if (locked_out) cnt++;
            else break;
        end
        check("lockout_len", 32'(cnt), 32'(16));
        check("lockout_exit", 32'(dut_bundle()), 32'({1'b0, 1'b0, 3'd0, 4'd0, L_LOCKED}));

        // ---- rewrite combination while unlocked ----
        dial(0, 0); dial(1, 1); dial(1, 7); dial(0, 3); dial(1, 20);
        check("open_default", 32'(unlocked), 32'(1));
        dial_wr(1, 5, 3, 0);      // out-of-range index: ignored
        dial_wr(0, 9, 1, 2);      // write lands on the UNLOCKED->RELOCK edge
        check("relock_state", 32'(state_led), 32'(L_RELOCK));
        dial(0, 0);
        dial_wr(0, 5, 2, 1);      // write while LOCKED: ignored
        dial(0, 0); dial(1, 1); dial(1, 7); dial(0, 3);
        check("old_seq_step1_hold", 32'(step), 32'(1));
        dial(1, 20);
        check("old_seq_fails", 32'({fail_cnt, state_led}), 32'({4'd1, L_LOCKED}));
        dial(0, 0); dial(1, 1); dial(1, 7); dial(0, 2); dial(1, 20);
        check("new_seq_opens", 32'({unlocked, fail_cnt}), 32'({1'b1, 4'd0}));

        // ---- reset mid-SEEK and mid-LOCKOUT ----
        dial(0, 0); dial(0, 0);
        dial(0, 0); dial(1, 1); dial(1, 9);
        dial(0, 0); dial(1, 1); dial(1, 7); dial(0, 2);
        check("seek_k2", 32'({step, fail_cnt}), 32'({3'd2, 4'd1}));
        cycle(1'b1, 1'b1, 20, 1'b0, 0, 0, 1'b1, "model_rst");
        check("reset_mid_seek", 32'(dut_bundle()), 32'({1'b0, 1'b0, 3'd0, 4'd0, L_LOCKED}));
        for (int a = 0; a < 3; a++) begin
            dial(0, 0); dial(1, 1); dial(1, 9);
        end
        for (int i = 0; i < 5; i++) dial(1, 1);
        check("in_lockout", 32'(locked_out), 32'(1));
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, "model_rst");
        check("reset_mid_lockout", 32'(dut_bundle()), 32'({1'b0, 1'b0, 3'd0, 4'd0, L_LOCKED}));
        dial(0, 0); dial(1, 1); dial(1, 7); dial(0, 3); dial(1, 20);
        check("comb_restored", 32'(unlocked), 32'(1));

        // ---- randomized run against the model ----
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: cval = 0;
                1: cval = m_comb[m_k];
                2: cval = (m_k > 0) ? m_comb[m_k-1] : 0;
                3: cval = m_comb[m_k] + 1;
                4: cval = m_comb[m_k] - 1;
                default: cval = int'($urandom % 32);
            endcase
            cycle(($urandom_range(0, 199) == 0), 1'($urandom % 2), cval,
                  ($urandom % 4 == 0), int'($urandom % 4), int'($urandom % 32),
                  1'b1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
